// File: rtl/femto_uart.sv
// femto_uart: a small memory-mapped UART for a SoC iomem port.
// Register window of 16 bytes: DATA, STATUS, DIV, reserved.
// TX path: byte FIFO feeding an 8N1 shifter. RX path: 2-flop synchroniser,
// centre-sampling receiver, single holding register with sticky error flags.
module femto_uart #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter logic [15:0] RESET_DIV = 16'd104,
    parameter int          TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int PW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Bus side
    logic        ready_r;
    logic [31:0] rdata_r;
    logic        sel_s, req_s, accept_s, wr_s;
    logic        is_data_s, is_status_s, is_div_s;
    logic        push_req_s, push_s, rd_clear_s;
    logic [31:0] rd_val_s;

    // Configuration
    logic [15:0] div_r;
    logic [15:0] div_eff_s;

    // TX FIFO
    logic [7:0]    fifo_mem_r [TX_DEPTH];
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          fifo_full_s, fifo_empty_s;

    // TX shifter
    tx_state_t   tx_state_r, tx_state_s;
    logic [15:0] tx_cnt_r, tx_cnt_s;
    logic [2:0]  tx_bit_r, tx_bit_s;
    logic [7:0]  tx_shift_r, tx_shift_s;
    logic        tx_out_r, tx_out_s;
    logic        pop_s, tx_idle_s;

    // RX receiver
    logic        rx_meta_r, rx_sync_r, rx_prev_r;
    rx_state_t   rx_state_r, rx_state_s;
    logic [15:0] rx_cnt_r, rx_cnt_s;
    logic [2:0]  rx_bit_r, rx_bit_s;
    logic [7:0]  rx_shift_r, rx_shift_s;
    logic        rx_done_s, ferr_set_s;
    logic [7:0]  rx_byte_r;
    logic        rx_valid_r, rx_overrun_r, frame_err_r;
    logic        ovr_set_s;

    logic unused_s;
    assign unused_s = ^{iomem_addr[1:0], iomem_wstrb[3:2], iomem_wdata[31:16]};

    assign iomem_ready = ready_r;
    assign iomem_rdata = rdata_r;
    assign uart_tx     = tx_out_r;

    // A divisor below 4 would leave no room for the half-bit start check.
    assign div_eff_s    = (div_r < 16'd4) ? 16'd4 : div_r;
    assign fifo_full_s  = (count_r == CW'(TX_DEPTH));
    assign fifo_empty_s = (count_r == {CW{1'b0}});
    assign tx_idle_s    = fifo_empty_s && (tx_state_r == TX_IDLE);

    // Decode. A request is not taken in the cycle its ready pulse is shown,
    // so a held valid cannot complete twice.
    assign sel_s       = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    assign req_s       = sel_s && !ready_r;
    assign wr_s        = |iomem_wstrb;
    assign is_data_s   = (iomem_addr[3:2] == 2'd0);
    assign is_status_s = (iomem_addr[3:2] == 2'd1);
    assign is_div_s    = (iomem_addr[3:2] == 2'd2);
    assign push_req_s  = req_s && is_data_s && iomem_wstrb[0];
    // A push into a full FIFO waits, but succeeds in the cycle the shifter pops.
    assign accept_s    = req_s && (!push_req_s || !fifo_full_s || pop_s);
    assign push_s      = accept_s && push_req_s;
    assign rd_clear_s  = accept_s && !wr_s && is_data_s && rx_valid_r;
    assign ovr_set_s   = rx_done_s && rx_valid_r && !rd_clear_s;

    // Read mux for the register window.
    always_comb begin
        rd_val_s = 32'd0;
        case (iomem_addr[3:2])
            2'd0:    rd_val_s = rx_valid_r ? {23'd0, 1'b1, rx_byte_r} : 32'd0;
            2'd1:    rd_val_s = {27'd0, frame_err_r, rx_overrun_r, rx_valid_r,
                                 tx_idle_s, fifo_full_s};
            2'd2:    rd_val_s = {16'd0, div_r};
            default: rd_val_s = 32'd0;
        endcase
    end

    // Bus completion pulse and read data, zero outside the pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_r <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            ready_r <= accept_s;
            rdata_r <= (accept_s && !wr_s) ? rd_val_s : 32'd0;
        end
    end

    // Baud divisor register, byte-writable.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r <= RESET_DIV;
        end else if (accept_s && wr_s && is_div_s) begin
            if (iomem_wstrb[0]) div_r[7:0]  <= iomem_wdata[7:0];
            if (iomem_wstrb[1]) div_r[15:8] <= iomem_wdata[15:8];
        end
    end

    // FIFO storage; contents are don't-care until pointers say otherwise.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= iomem_wdata[7:0];
    end

    // FIFO pointers and occupancy; push and pop together leave count alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // TX next state: each bit lasts the divisor sampled at its start, and the
    // stop bit's last cycle pops the next byte so frames run gap-free.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_out_s   = tx_out_r;
        pop_s      = 1'b0;
        case (tx_state_r)
            TX_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s      = 1'b1;
                    tx_shift_s = fifo_mem_r[rd_ptr_r];
                    tx_out_s   = 1'b0;
                    tx_cnt_s   = div_eff_s - 16'd1;
                    tx_state_s = TX_START;
                end else begin
                    tx_out_s   = 1'b1;
                end
            end
            TX_START: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_state_s = TX_DATA;
                    tx_out_s   = tx_shift_r[0];
                    tx_bit_s   = 3'd0;
                    tx_cnt_s   = div_eff_s - 16'd1;
                end else begin
                    tx_cnt_s   = tx_cnt_r - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_r == 16'd0) begin
                    tx_cnt_s = div_eff_s - 16'd1;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = TX_STOP;
                        tx_out_s   = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        tx_out_s   = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_r == 16'd0) begin
                    if (!fifo_empty_s) begin
                        pop_s      = 1'b1;
                        tx_shift_s = fifo_mem_r[rd_ptr_r];
                        tx_out_s   = 1'b0;
                        tx_cnt_s   = div_eff_s - 16'd1;
                        tx_state_s = TX_START;
                    end else begin
                        tx_out_s   = 1'b1;
                        tx_state_s = TX_IDLE;
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r - 16'd1;
                end
            end
            default: begin
                tx_state_s = TX_IDLE;
                tx_out_s   = 1'b1;
            end
        endcase
    end

    // TX state register; the line output is registered and idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_r <= TX_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_out_r   <= 1'b1;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_out_r   <= tx_out_s;
        end
    end

    // RX synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX next state: half-bit start check rejects glitches, then one sample
    // per bit period from the start-bit centre, LSB first.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_done_s  = 1'b0;
        ferr_set_s = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    rx_state_s = RX_START;
                    rx_cnt_s   = (div_eff_s >> 1) - 16'd1;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (rx_cnt_r == 16'd0) begin
                    if (rx_sync_r) begin
                        rx_state_s = RX_IDLE;
                    end else begin
                        rx_state_s = RX_DATA;
                        rx_bit_s   = 3'd0;
                        rx_cnt_s   = div_eff_s - 16'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    rx_cnt_s   = div_eff_s - 16'd1;
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        rx_bit_s   = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_r == 16'd0) begin
                    rx_state_s = RX_IDLE;
                    if (rx_sync_r) begin
                        rx_done_s  = 1'b1;
                    end else begin
                        ferr_set_s = 1'b1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r - 16'd1;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
            end
        endcase
    end

    // RX state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_r <= RX_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
        end
    end

    // RX holding register and sticky flags. A read clearing rx_valid in the
    // same cycle a byte lands frees the slot for that byte; a new error event
    // beats a simultaneous software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte_r    <= 8'd0;
            rx_valid_r   <= 1'b0;
            rx_overrun_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            if (rx_done_s && !ovr_set_s) begin
                rx_byte_r  <= rx_shift_r;
                rx_valid_r <= 1'b1;
            end else if (rd_clear_s) begin
                rx_valid_r <= 1'b0;
            end

            if (ovr_set_s) begin
                rx_overrun_r <= 1'b1;
            end else if (accept_s && is_status_s && iomem_wstrb[0] && iomem_wdata[3]) begin
                rx_overrun_r <= 1'b0;
            end

            if (ferr_set_s) begin
                frame_err_r <= 1'b1;
            end else if (accept_s && is_status_s && iomem_wstrb[0] && iomem_wdata[4]) begin
                frame_err_r <= 1'b0;
            end
        end
    end

endmodule
